// File: rtl/gate_op_arbiter_pkg.sv
// Shared encodings for the gate-op arbiter: operation codes, FSM states
// and the legal bounds of the EXEC settle latency.
package gate_op_arbiter_pkg;

  // Operation select codes presented on reqN_op
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_NOTA = 2'b10;
  localparam logic [1:0] OP_XOR  = 2'b11;

  // Arbiter FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  // EXEC settle latency bounds; the counter only has to reach LAT_MAX-1
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;
  localparam int CNT_W   = 2;

endpackage

// File: rtl/gate_op_arbiter_gates.sv
// Shared 1-bit basic gates unit; every gate is computed in parallel and the
// arbiter picks one with its op-select mux.
module basic_gates
  import gate_op_arbiter_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic and_out,
  output logic or_out,
  output logic not_a,
  output logic xor_out
);

  // Purely combinational gate outputs
  always_comb begin
    and_out = a & b;
    or_out  = a | b;
    not_a   = ~a;
    xor_out = a ^ b;
  end

endmodule

// File: rtl/gate_op_arbiter.sv
// Two-requester round-robin arbiter in front of one shared basic-gates unit.
// IDLE accepts one request, EXEC holds the latched operands for LAT cycles
// and captures the selected gate output, RESP strobes the owner's result.
module gate_op_arbiter
  import gate_op_arbiter_pkg::*;
#(
  parameter int LAT = 1  // EXEC settle cycles, LAT_MIN..LAT_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req0_a,
  input  logic       req0_b,
  input  logic [1:0] req0_op,
  output logic       req0_ready,
  output logic       rsp0_valid,
  output logic       rsp0_data,
  input  logic       req1_valid,
  input  logic       req1_a,
  input  logic       req1_b,
  input  logic [1:0] req1_op,
  output logic       req1_ready,
  output logic       rsp1_valid,
  output logic       rsp1_data,
  output logic       busy,
  output logic [1:0] grant
);

  // Counter value on the last EXEC cycle
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             result_q, result_d;
  logic             prio_q, prio_d;  // 1 means requester 1 wins a tie
  logic             pick1;
  logic             gate_sel;
  logic             and_w, or_w, nota_w, xor_w;

  basic_gates u_gates (
    .a       (a_q),
    .b       (b_q),
    .and_out (and_w),
    .or_out  (or_w),
    .not_a   (nota_w),
    .xor_out (xor_w)
  );

  // Winner selection and op-select mux over the shared gate outputs
  always_comb begin
    pick1 = req1_valid & (~req0_valid | prio_q);
    case (op_q)
      OP_AND:  gate_sel = and_w;
      OP_OR:   gate_sel = or_w;
      OP_NOTA: gate_sel = nota_w;
      default: gate_sel = xor_w;
    endcase
  end

  // FSM next-state, operand latching, round-robin update and result capture
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    result_d   = result_q;
    prio_d     = prio_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rst_n && (req0_valid || req1_valid)) begin
          req0_ready = ~pick1;
          req1_ready = pick1;
          a_d        = pick1 ? req1_a  : req0_a;
          b_d        = pick1 ? req1_b  : req0_b;
          op_d       = pick1 ? req1_op : req0_op;
          grant_d    = pick1 ? 2'b10 : 2'b01;
          prio_d     = ~pick1;
          cnt_d      = '0;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == CNT_LAST) begin
          result_d = gate_sel;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= 2'b00;
      cnt_q    <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      op_q     <= OP_AND;
      result_q <= 1'b0;
      prio_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      prio_q   <= prio_d;
    end
  end

  // Output decode; response data is forced low outside its strobe
  always_comb begin
    busy       = (state_q == ST_EXEC) || (state_q == ST_RESP);
    grant      = grant_q;
    rsp0_valid = (state_q == ST_RESP) && grant_q[0];
    rsp1_valid = (state_q == ST_RESP) && grant_q[1];
    rsp0_data  = rsp0_valid & result_q;
    rsp1_data  = rsp1_valid & result_q;
  end

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Directed self-checking bench for gate_op_arbiter: a LAT=1 instance for the
// main sequence and a LAT=4 instance for the long-latency case.
module tb_gate_op_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       r0v, r0a, r0b, r0rdy, s0v, s0d;
  logic       r1v, r1a, r1b, r1rdy, s1v, s1d;
  logic [1:0] r0op, r1op, grant;
  logic       busy;

  logic       f0v, f0a, f0b, f0rdy, fs0v, fs0d;
  logic       f1v, f1a, f1b, f1rdy, fs1v, fs1d;
  logic [1:0] f0op, f1op, fgrant;
  logic       fbusy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int   id;
    logic data;
    int   acc;
  } exp_t;
  exp_t sb[$];

  gate_op_arbiter #(.LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_a(r0a), .req0_b(r0b), .req0_op(r0op), .req0_ready(r0rdy),
    .rsp0_valid(s0v), .rsp0_data(s0d),
    .req1_valid(r1v), .req1_a(r1a), .req1_b(r1b), .req1_op(r1op), .req1_ready(r1rdy),
    .rsp1_valid(s1v), .rsp1_data(s1d),
    .busy(busy), .grant(grant)
  );

  gate_op_arbiter #(.LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(f0v), .req0_a(f0a), .req0_b(f0b), .req0_op(f0op), .req0_ready(f0rdy),
    .rsp0_valid(fs0v), .rsp0_data(fs0d),
    .req1_valid(f1v), .req1_a(f1a), .req1_b(f1b), .req1_op(f1op), .req1_ready(f1rdy),
    .rsp1_valid(fs1v), .rsp1_data(fs1d),
    .busy(fbusy), .grant(fgrant)
  );

  // Free-running cycle index, used to measure accept/response spacing
  always @(posedge clk) cyc <= cyc + 1;

  // Reference truth table for the shared gate unit
  function automatic logic model(input logic a, input logic b, input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return ~a;
      default: return a ^ b;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Every output of both instances must be quiet while reset is held
  task automatic resetChecks();
    checkOutput("rst_ready",  {r0rdy, r1rdy, f0rdy, f1rdy}, 0);
    checkOutput("rst_rspv",   {s0v, s1v, fs0v, fs1v}, 0);
    checkOutput("rst_rspd",   {s0d, s1d, fs0d, fs1d}, 0);
    checkOutput("rst_busy",   {busy, fbusy}, 0);
    checkOutput("rst_grant",  {grant, fgrant}, 0);
  endtask

  // Present a request on the LAT=1 instance, wait for its accept, push the
  // expected result, then drop valid and scramble the operands
  task automatic applyStimulus(input int id, input logic a, input logic b,
                               input logic [1:0] op, output int waited);
    bit seen;
    seen = 0;
    waited = 0;
    if (id == 0) begin r0v = 1; r0a = a; r0b = b; r0op = op; end
    else         begin r1v = 1; r1a = a; r1b = b; r1op = op; end
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      waited++;
      if ((id == 0 && r0rdy) || (id == 1 && r1rdy)) seen = 1;
    end
    checkOutput("accept_seen", 16'(seen), 1);
    if (seen) sb.push_back('{id: id, data: model(a, b, op), acc: cyc});
    @(posedge clk);
    #1;
    if (id == 0) begin r0v = 0; r0a = ~a; r0b = ~b; r0op = op ^ 2'b01; end
    else         begin r1v = 0; r1a = ~a; r1b = ~b; r1op = op ^ 2'b01; end
  endtask

  // Pop the scoreboard head and compare it with the strobing response
  task automatic checkResp(input int lat);
    exp_t e;
    checkOutput("sb_nonempty", 16'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("rsp_owner",   {s1v, s0v}, (e.id == 0) ? 2'b01 : 2'b10);
      checkOutput("rsp_data",    (e.id == 0) ? s0d : s1d, e.data);
      checkOutput("rsp_latency", 16'(cyc - e.acc), 16'(lat + 1));
      checkOutput("rsp_grant",   grant, (e.id == 0) ? 2'b01 : 2'b10);
    end
  endtask

  task automatic waitResponse(input int lat);
    bit seen;
    seen = 0;
    for (int n = 0; n < 12 && !seen; n++) begin
      @(negedge clk);
      if (s0v || s1v) seen = 1;
    end
    checkOutput("rsp_seen", 16'(seen), 1);
    if (seen) checkResp(lat);
  endtask

  // Continuous protocol checks: exclusive readies/responses, no ready while busy
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("mutex_ready", {r0rdy & r1rdy, f0rdy & f1rdy}, 0);
      checkOutput("mutex_rsp",   {s0v & s1v, fs0v & fs1v}, 0);
      checkOutput("ready_busy",  {busy & (r0rdy | r1rdy), fbusy & (f0rdy | f1rdy)}, 0);
    end
  end

  // Hard stop if the sequence ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence
  initial begin
    int w, acc0, accepts, lastAcc;
    bit seen;
    r0v = 1; r0a = 1; r0b = 1; r0op = 2'b00;
    r1v = 0; r1a = 0; r1b = 0; r1op = 2'b00;
    f0v = 0; f0a = 0; f0b = 0; f0op = 2'b00;
    f1v = 0; f1a = 0; f1b = 0; f1op = 2'b00;

    // Reset values, then the first accept on the first edge after release
    repeat (2) @(negedge clk);
    resetChecks();
    @(posedge clk);
    #1 rst_n = 1;
    applyStimulus(0, 1, 1, 2'b00, w);
    checkOutput("first_accept_wait", 16'(w), 1);
    @(negedge clk);
    checkOutput("exec_grant", grant, 2'b01);
    checkOutput("exec_busy", 16'(busy), 1);
    waitResponse(1);

    // Full truth table on requester 1
    for (int op = 0; op < 4; op++) begin
      for (int ab = 0; ab < 4; ab++) begin
        applyStimulus(1, ab[1], ab[0], 2'(op), w);
        waitResponse(1);
      end
    end

    // Requester 1 arriving during requester 0's EXEC waits for the next IDLE
    applyStimulus(0, 0, 1, 2'b01, w);
    acc0 = sb[$].acc;
    r1v = 1; r1a = 1; r1b = 0; r1op = 2'b11;
    waitResponse(1);
    applyStimulus(1, 1, 0, 2'b11, w);
    checkOutput("late_req_wait", 16'(w), 1);
    checkOutput("late_req_gap", 16'(sb[$].acc - acc0), 3);
    waitResponse(1);

    // Round-robin with both requesters valid from reset
    @(posedge clk);
    #1 rst_n = 0;
    r0v = 1; r0a = 1; r0b = 0; r0op = 2'b01;
    r1v = 1; r1a = 1; r1b = 1; r1op = 2'b11;
    @(negedge clk);
    resetChecks();
    @(posedge clk);
    #1 rst_n = 1;
    accepts = 0;
    lastAcc = 0;
    for (int n = 0; n < 20 && accepts < 4; n++) begin
      @(negedge clk);
      if (s0v || s1v) checkResp(1);
      if (r0rdy || r1rdy) begin
        checkOutput("rr_order", 16'(r1rdy), 16'(accepts % 2));
        if (accepts > 0) checkOutput("rr_spacing", 16'(cyc - lastAcc), 3);
        if (r1rdy) sb.push_back('{id: 1, data: model(r1a, r1b, r1op), acc: cyc});
        else       sb.push_back('{id: 0, data: model(r0a, r0b, r0op), acc: cyc});
        accepts++;
        lastAcc = cyc;
      end
    end
    checkOutput("rr_accepts", 16'(accepts), 4);
    @(posedge clk);
    #1 r0v = 0; r1v = 0;
    waitResponse(1);

    // Reset during EXEC drops the request; the re-presented one completes
    applyStimulus(0, 1, 0, 2'b11, w);
    void'(sb.pop_back());
    rst_n = 0;
    repeat (3) begin
      @(negedge clk);
      resetChecks();
    end
    @(posedge clk);
    #1 rst_n = 1;
    applyStimulus(0, 1, 0, 2'b11, w);
    checkOutput("reissue_wait", 16'(w), 1);
    waitResponse(1);

    // LAT=4 instance: operands flipped after accept must not leak in
    f0v = 1; f0a = 0; f0b = 1; f0op = 2'b11;
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (f0rdy) seen = 1;
    end
    checkOutput("lat4_accept", 16'(seen), 1);
    acc0 = cyc;
    @(posedge clk);
    #1 f0v = 0; f0a = 1; f0b = 0; f0op = 2'b00;
    @(negedge clk);
    checkOutput("lat4_busy", 16'(fbusy), 1);
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      if (fs0v) seen = 1;
      else @(negedge clk);
    end
    checkOutput("lat4_rsp_seen", 16'(seen), 1);
    checkOutput("lat4_latency", 16'(cyc - acc0), 5);
    checkOutput("lat4_data", 16'(fs0d), 1);
    checkOutput("lat4_grant", fgrant, 2'b01);

    @(negedge clk);
    checkOutput("sb_drained", 16'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
